// File: rtl/dd2_sub_bus_pkg.sv
// Shared constants and decode types for the Double Dragon II sub-CPU bus shell.
package dd2_sub_bus_pkg;

    localparam logic [1:0] ROM_TOP  = 2'b11;
    localparam logic [3:0] SHARED   = 4'hC;
    localparam logic [3:0] NMIACK   = 4'hD;
    localparam logic [3:0] IRQMAIN  = 4'hE;
    localparam logic [7:0] OPEN_BUS = 8'hFF;

    typedef struct packed {
        logic rom;
        logic shared;
        logic nmi_ack;
        logic irqmain;
    } dec_t;

    function automatic dec_t decode(input logic mreq_n, input logic wr_n, input logic [15:0] a);
        dec_t d;
        d = '0;
        if (!mreq_n) begin
            if (a[15:14] != ROM_TOP) begin
                d.rom = 1'b1;
            end else begin
                case (a[15:12])
                    SHARED:  d.shared  = 1'b1;
                    NMIACK:  d.nmi_ack = ~wr_n;
                    IRQMAIN: d.irqmain = ~wr_n;
                    default: ;
                endcase
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/dd2_dpram.sv
// Generic dual-port byte RAM, 1-clk read latency, read-old-data on write,
// port A takes priority when both ports write the same address.
module dd2_dpram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] a_addr_i,
    input  logic          a_we_i,
    input  logic [7:0]    a_din_i,
    output logic [7:0]    a_q_o,
    input  logic [AW-1:0] b_addr_i,
    input  logic          b_we_i,
    input  logic [7:0]    b_din_i,
    output logic [7:0]    b_q_o
);

    logic [7:0] mem [2**AW];
    logic [7:0] a_q_q, b_q_q;

    // Port A written last so it overrides port B on a same-address collision.
    always_ff @(posedge clk) begin
        if (b_we_i) mem[b_addr_i] <= b_din_i;
        if (a_we_i) mem[a_addr_i] <= a_din_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q_q <= '0;
            b_q_q <= '0;
        end else begin
            a_q_q <= mem[a_addr_i];
            b_q_q <= mem[b_addr_i];
        end
    end

    assign a_q_o = a_q_q;
    assign b_q_o = b_q_q;

endmodule

// File: rtl/dd2_sub_bus.sv
// Sub-CPU bus shell: address decode, ROM wait gating, shared RAM and NMI latch.
module dd2_sub_bus
    import dd2_sub_bus_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen4,
    input  logic [9:0]  main_AB,
    input  logic        main_wrn,
    input  logic [7:0]  main_dout,
    output logic [7:0]  shared_dout,
    input  logic        com_cs,
    input  logic        mcu_halt,
    input  logic        mcu_nmi_set,
    output logic        mcu_ban,
    output logic        mcu_irqmain,
    input  logic [15:0] cpu_A,
    input  logic        cpu_mreq_n,
    input  logic        cpu_wr_n,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_busak_n,
    output logic [7:0]  cpu_din,
    output logic        cpu_nmi_n,
    output logic        cpu_busrq_n,
    output logic        cpu_cen,
    output logic [15:0] rom_addr,
    output logic        rom_cs,
    input  logic [7:0]  rom_data,
    input  logic        rom_ok
);

    dec_t       dec;
    logic [7:0] ram_a_q;
    logic       nmi_prev_q, nmi_q, nmi_d;

    assign dec         = decode(cpu_mreq_n, cpu_wr_n, cpu_A);
    assign rom_cs      = dec.rom;
    assign mcu_irqmain = dec.irqmain;
    assign rom_addr    = cpu_A;
    assign mcu_ban     = cpu_busak_n;
    assign cpu_busrq_n = ~mcu_halt;

    // A cen4 pulse that lands while ROM data is pending is lost, not queued.
    assign cpu_cen = cen4 & ~(dec.rom & ~rom_ok);

    always_comb begin
        cpu_din = OPEN_BUS;
        if (dec.rom)         cpu_din = rom_data;
        else if (dec.shared) cpu_din = ram_a_q;
    end

    // Acknowledge beats a simultaneous new edge.
    always_comb begin
        nmi_d = nmi_q;
        if (dec.nmi_ack)                      nmi_d = 1'b0;
        else if (mcu_nmi_set && !nmi_prev_q) nmi_d = 1'b1;
    end

    // prev keeps tracking through reset so a level held across release is not an edge.
    always_ff @(posedge clk) begin
        nmi_prev_q <= mcu_nmi_set;
        if (rst) nmi_q <= 1'b0;
        else     nmi_q <= nmi_d;
    end

    assign cpu_nmi_n = ~nmi_q;

    dd2_dpram #(.AW(AW)) u_ram (
        .clk      (clk),
        .rst      (rst),
        .a_addr_i (cpu_A[AW-1:0]),
        .a_we_i   (dec.shared & ~cpu_wr_n),
        .a_din_i  (cpu_dout),
        .a_q_o    (ram_a_q),
        .b_addr_i (main_AB[AW-1:0]),
        .b_we_i   (~main_wrn & com_cs & ~cpu_busak_n),
        .b_din_i  (main_dout),
        .b_q_o    (shared_dout)
    );

endmodule

// File: tb/tb_dd2_sub_bus.sv
// Randomized + directed bench for dd2_sub_bus with a queue-based scoreboard.
module tb_dd2_sub_bus;

    logic        clk = 1'b0;
    logic        rst, cen4, main_wrn, com_cs, mcu_halt, mcu_nmi_set;
    logic        cpu_mreq_n, cpu_wr_n, cpu_busak_n, rom_ok;
    logic [9:0]  main_AB;
    logic [7:0]  main_dout, cpu_dout, rom_data;
    logic [15:0] cpu_A;
    logic [7:0]  shared_dout, cpu_din;
    logic        mcu_ban, mcu_irqmain, cpu_nmi_n, cpu_busrq_n, cpu_cen, rom_cs;
    logic [15:0] rom_addr;

    dd2_sub_bus #(.AW(10)) dut (
        .clk(clk), .rst(rst), .cen4(cen4),
        .main_AB(main_AB), .main_wrn(main_wrn), .main_dout(main_dout),
        .shared_dout(shared_dout), .com_cs(com_cs), .mcu_halt(mcu_halt),
        .mcu_nmi_set(mcu_nmi_set), .mcu_ban(mcu_ban), .mcu_irqmain(mcu_irqmain),
        .cpu_A(cpu_A), .cpu_mreq_n(cpu_mreq_n), .cpu_wr_n(cpu_wr_n),
        .cpu_dout(cpu_dout), .cpu_busak_n(cpu_busak_n), .cpu_din(cpu_din),
        .cpu_nmi_n(cpu_nmi_n), .cpu_busrq_n(cpu_busrq_n), .cpu_cen(cpu_cen),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  din;
        logic        cen;
        logic        rcs;
        logic [15:0] raddr;
        logic        nmi_n;
        logic        irq;
        logic [7:0]  sdout;
        logic        busrq_n;
        logic        ban;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 0;

    // Reference model state
    logic [7:0] m_mem [1024];
    logic [7:0] m_qa = 8'h00, m_qb = 8'h00;
    bit         m_nmi = 0, m_last = 0;

    task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
        end
    endtask

    // Builds expectations for the current inputs, then advances the model across the next edge.
    task automatic step();
        exp_t e;
        bit mreq, rom, sh, ack, irq;
        logic [7:0] nqa, nqb;
        int region;
        mreq   = !cpu_mreq_n;
        region = int'(cpu_A) / 4096;
        rom    = mreq && (cpu_A < 16'hC000);
        sh     = mreq && region == 12;
        ack    = mreq && region == 13 && !cpu_wr_n;
        irq    = mreq && region == 14 && !cpu_wr_n;
        e.din     = rom ? rom_data : (sh ? m_qa : 8'hFF);
        e.cen     = cen4 && !(rom && !rom_ok);
        e.rcs     = rom;
        e.raddr   = cpu_A;
        e.nmi_n   = !m_nmi;
        e.irq     = irq;
        e.sdout   = m_qb;
        e.busrq_n = !mcu_halt;
        e.ban     = cpu_busak_n;
        if (chk_en && !rst) exp_q.push_back(e);

        nqa = m_mem[cpu_A[9:0]];
        nqb = m_mem[main_AB];
        if (rst) begin
            m_qa = 8'h00; m_qb = 8'h00; m_nmi = 0;
        end else begin
            m_qa = nqa; m_qb = nqb;
            if (ack) m_nmi = 0;
            else if (mcu_nmi_set && !m_last) m_nmi = 1;
        end
        if (!main_wrn && com_cs && !cpu_busak_n) m_mem[main_AB] = main_dout;
        if (sh && !cpu_wr_n) m_mem[cpu_A[9:0]] = cpu_dout;
        m_last = mcu_nmi_set;
        @(posedge clk); #1;
    endtask

    task automatic sub(input logic [15:0] a, input logic mreq_n, input logic wr_n, input logic [7:0] d);
        cpu_A = a; cpu_mreq_n = mreq_n; cpu_wr_n = wr_n; cpu_dout = d;
    endtask

    task automatic mainbus(input logic [9:0] a, input logic wrn, input logic cs, input logic [7:0] d);
        main_AB = a; main_wrn = wrn; com_cs = cs; main_dout = d;
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cmp("cpu_din",     16'(cpu_din),     16'(e.din));
                cmp("cpu_cen",     16'(cpu_cen),     16'(e.cen));
                cmp("rom_cs",      16'(rom_cs),      16'(e.rcs));
                cmp("rom_addr",    rom_addr,         e.raddr);
                cmp("cpu_nmi_n",   16'(cpu_nmi_n),   16'(e.nmi_n));
                cmp("mcu_irqmain", 16'(mcu_irqmain), 16'(e.irq));
                cmp("shared_dout", 16'(shared_dout), 16'(e.sdout));
                cmp("cpu_busrq_n", 16'(cpu_busrq_n), 16'(e.busrq_n));
                cmp("mcu_ban",     16'(mcu_ban),     16'(e.ban));
            end
        end
    end

    initial begin
        rst = 1; cen4 = 0; mcu_halt = 0; mcu_nmi_set = 0; cpu_busak_n = 1;
        rom_ok = 0; rom_data = 8'h00;
        sub(16'hF000, 1'b1, 1'b1, 8'h00);
        mainbus(10'h000, 1'b1, 1'b0, 8'h00);
        @(posedge clk); #1;
        step(); step();
        rst = 0;

        // Fill RAM through the main port so every later read is defined.
        cpu_busak_n = 0;
        for (int i = 0; i < 1024; i++) begin
            mainbus(10'(i), 1'b0, 1'b1, 8'($urandom));
            step();
        end
        mainbus(10'h000, 1'b1, 1'b0, 8'h00);
        cpu_busak_n = 1;
        chk_en = 1;

        // Reset with NMI request held high: no NMI after release, q regs cleared.
        rst = 1; mcu_nmi_set = 1;
        step(); step();
        rst = 0;
        step(); step();

        // ROM wait
        sub(16'h1234, 1'b0, 1'b1, 8'h00); rom_ok = 0;
        cen4 = 1; step(); cen4 = 0; step(); cen4 = 1; step();
        rom_ok = 1; rom_data = 8'h5A;
        cen4 = 1; step(); cen4 = 0; step();
        rom_ok = 0;

        // Sub writes shared, main reads back
        sub(16'hC3FF, 1'b0, 1'b0, 8'hA5); step();
        sub(16'hF000, 1'b1, 1'b1, 8'h00);
        mainbus(10'h3FF, 1'b1, 1'b1, 8'h00); step(); step();
        // Main write ignored while sub owns the bus
        mainbus(10'h010, 1'b0, 1'b1, 8'h77); cpu_busak_n = 1; step();
        mainbus(10'h010, 1'b1, 1'b1, 8'h00); step(); step();
        // Main write accepted once sub is halted
        cpu_busak_n = 0; mainbus(10'h010, 1'b0, 1'b1, 8'h3C); step();
        mainbus(10'h010, 1'b1, 1'b0, 8'h00); cpu_busak_n = 1;
        sub(16'hC010, 1'b0, 1'b1, 8'h00); step(); step();

        // NMI edge, hold, ack, ack coincident with edge
        sub(16'hF000, 1'b1, 1'b1, 8'h00);
        mcu_nmi_set = 0; step();
        mcu_nmi_set = 1; step(); step(); step();
        sub(16'hD000, 1'b0, 1'b0, 8'h00); step();
        sub(16'hF000, 1'b1, 1'b1, 8'h00); step();
        mcu_nmi_set = 0; step();
        mcu_nmi_set = 1; sub(16'hD000, 1'b0, 1'b0, 8'h00); step();
        sub(16'hF000, 1'b1, 1'b1, 8'h00); step(); step();

        // IRQ strobe and open bus
        sub(16'hE000, 1'b0, 1'b0, 8'h11); step();
        sub(16'hE000, 1'b0, 1'b1, 8'h00); step();
        sub(16'hF000, 1'b0, 1'b1, 8'h00); step();

        // Bus request / acknowledge
        mcu_halt = 1; step();
        cpu_busak_n = 0; step();
        mcu_halt = 0; cpu_busak_n = 1; step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if ($urandom_range(0, 2) == 0) a = {4'hC, a[11:0]};
            sub(a, 1'($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom));
            mainbus(10'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            cen4        = 1'($urandom);
            rom_ok      = 1'($urandom);
            rom_data    = 8'($urandom);
            cpu_busak_n = 1'($urandom);
            mcu_halt    = 1'($urandom);
            if ($urandom_range(0, 3) == 0) mcu_nmi_set = ~mcu_nmi_set;
            step();
        end

        chk_en = 0;
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
